// File: rtl/serial_tx_clkdiv.sv
// serial_tx_clkdiv
// Serial transmitter that sits just downstream of the clock generator. The
// divided clock from the generator is treated as an ordinary signal in the
// in_clk domain. Its falling edges are detected and used as a strobe. Each
// parallel word is shifted out MSB- or LSB-first. A gated copy of the divided
// clock is also driven out, for SPI-style peripherals that sample on the
// rising edge. Every output is a register clocked by in_clk.
//
// Ports:
//   in_clk          main clock
//   in_rst          synchronous active-high reset
//   in_serial_clk   divided clock from the generator (same domain as in_clk)
//   in_enable       level request to transmit in_parallel
//   in_parallel     word to send, sampled only when a word is loaded
//   out_ready       1 while idle with nothing pending
//   out_word_done   one-cycle pulse after the last bit of a word is shifted
//   out_serial      serial data, changes only after falling strobe edges
//   out_serial_clk  serial clock to the peripheral, idles at its inactive level
module serial_tx_clkdiv #(
  parameter int BITS                 = 8,
  parameter bit LOWBIT_FIRST         = 1'b0,
  parameter bit SERIAL_CLK_INACTIVE  = 1'b1,
  parameter bit SERIAL_DATA_INACTIVE = 1'b0
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial_clk,
  input  logic            in_enable,
  input  logic [BITS-1:0] in_parallel,
  output logic            out_ready,
  output logic            out_word_done,
  output logic            out_serial,
  output logic            out_serial_clk
);

  localparam int             CW       = $clog2(BITS);
  localparam logic [CW-1:0]  LAST_BIT = CW'(BITS - 1);

  typedef enum logic {
    IDLE,
    TRANSMIT
  } state_t;

  state_t          state;
  logic [BITS-1:0] shift_reg;
  logic [CW-1:0]   bit_count;
  logic            clk_prev;
  logic            fall;
  logic            first_bit;
  logic            next_bit;
  logic [BITS-1:0] shifted;

  // A falling edge of the divided clock is the only event that moves data.
  // The shift direction is fixed by LOWBIT_FIRST. The bit that goes out
  // next is always the one adjacent to the bit currently on the line.
  assign fall      = clk_prev & ~in_serial_clk;
  assign first_bit = LOWBIT_FIRST ? in_parallel[0] : in_parallel[BITS-1];
  assign next_bit  = LOWBIT_FIRST ? shift_reg[1]   : shift_reg[BITS-2];
  assign shifted   = LOWBIT_FIRST ? (shift_reg >> 1) : (shift_reg << 1);

  // Main transmit state machine. The serial clock output is passed through
  // with one in_clk of delay. That delay matches the delay of the data
  // register, so a bit change on out_serial lines up with the falling edge
  // of out_serial_clk. When a word ends with in_enable still high, the next
  // word is loaded on the same fall. No idle clock period is inserted.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state          <= IDLE;
      out_ready      <= 1'b1;
      out_word_done  <= 1'b0;
      out_serial     <= SERIAL_DATA_INACTIVE;
      out_serial_clk <= SERIAL_CLK_INACTIVE;
      bit_count      <= '0;
      shift_reg      <= '0;
      clk_prev       <= SERIAL_CLK_INACTIVE;
    end else begin
      clk_prev      <= in_serial_clk;
      out_word_done <= 1'b0;
      case (state)
        IDLE: begin
          out_serial     <= SERIAL_DATA_INACTIVE;
          out_serial_clk <= SERIAL_CLK_INACTIVE;
          out_ready      <= 1'b1;
          if (fall && in_enable) begin
            shift_reg      <= in_parallel;
            bit_count      <= '0;
            out_serial     <= first_bit;
            out_serial_clk <= in_serial_clk;
            out_ready      <= 1'b0;
            state          <= TRANSMIT;
          end
        end
        TRANSMIT: begin
          out_serial_clk <= in_serial_clk;
          if (fall) begin
            if (bit_count != LAST_BIT) begin
              shift_reg  <= shifted;
              bit_count  <= bit_count + 1'b1;
              out_serial <= next_bit;
            end else begin
              out_word_done <= 1'b1;
              if (in_enable) begin
                shift_reg  <= in_parallel;
                bit_count  <= '0;
                out_serial <= first_bit;
              end else begin
                state          <= IDLE;
                out_ready      <= 1'b1;
                out_serial     <= SERIAL_DATA_INACTIVE;
                out_serial_clk <= SERIAL_CLK_INACTIVE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_clkdiv.sv
// tb_serial_tx_clkdiv
// Bench for serial_tx_clkdiv. Two instances share one set of stimulus:
//   dut_msb: MSB-first, serial clock idles high, data idles low
//   dut_lsb: LSB-first, serial clock idles low, data idles high
// The bench generates the divided clock itself. Directed sequences come
// first, then randomized segments. A cycle-level reference model predicts
// every output of both instances.
module tb_serial_tx_clkdiv;

  localparam int BITS    = 8;
  localparam int NUM_DUT = 2;

  logic            in_clk = 1'b0;
  logic            in_rst;
  logic            in_serial_clk;
  logic            in_enable;
  logic [BITS-1:0] in_parallel;

  logic ready_m, done_m, ser_m, sclk_m;
  logic ready_l, done_l, ser_l, sclk_l;

  int testCount = 0;
  int failCount = 0;
  int cycle     = 0;

  int sclkPeriod = 8;
  int sclkPhase  = 0;
  bit sclkRun    = 1'b1;

  int doneCount;
  int lastDoneCycle;
  int doneGap;

  bit mPrev  [NUM_DUT];
  bit mBusy  [NUM_DUT];
  bit mReady [NUM_DUT];
  bit mDone  [NUM_DUT];
  bit mSer   [NUM_DUT];
  bit mSclk  [NUM_DUT];
  bit mBits  [NUM_DUT][BITS];
  int mPos   [NUM_DUT];

  // Main clock: 10 time units per period.
  always #5 in_clk = ~in_clk;

  serial_tx_clkdiv #(
    .BITS(BITS), .LOWBIT_FIRST(1'b0),
    .SERIAL_CLK_INACTIVE(1'b1), .SERIAL_DATA_INACTIVE(1'b0)
  ) dut_msb (
    .in_clk(in_clk), .in_rst(in_rst), .in_serial_clk(in_serial_clk),
    .in_enable(in_enable), .in_parallel(in_parallel),
    .out_ready(ready_m), .out_word_done(done_m),
    .out_serial(ser_m), .out_serial_clk(sclk_m)
  );

  serial_tx_clkdiv #(
    .BITS(BITS), .LOWBIT_FIRST(1'b1),
    .SERIAL_CLK_INACTIVE(1'b0), .SERIAL_DATA_INACTIVE(1'b1)
  ) dut_lsb (
    .in_clk(in_clk), .in_rst(in_rst), .in_serial_clk(in_serial_clk),
    .in_enable(in_enable), .in_parallel(in_parallel),
    .out_ready(ready_l), .out_word_done(done_l),
    .out_serial(ser_l), .out_serial_clk(sclk_l)
  );

  function automatic bit lowFirst(input int i);
    return (i == 1);
  endfunction

  function automatic bit clkIdle(input int i);
    return (i == 0);
  endfunction

  function automatic bit dataIdle(input int i);
    return (i == 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               tag, cycle, obs, exp);
    end
  endtask

  // Reference model. A word is expanded into its bits in send order. Each
  // detected fall then advances a position through that list.
  task automatic loadWord(input int i, input logic [BITS-1:0] par);
    for (int k = 0; k < BITS; k++)
      mBits[i][k] = lowFirst(i) ? par[k] : par[BITS-1-k];
    mSer[i] = mBits[i][0];
    mPos[i] = 1;
  endtask

  task automatic modelStep(input int i, input bit rst, input bit sclk,
                           input bit en, input logic [BITS-1:0] par);
    bit fallNow;
    if (rst) begin
      mPrev[i]  = clkIdle(i);
      mBusy[i]  = 1'b0;
      mReady[i] = 1'b1;
      mDone[i]  = 1'b0;
      mSer[i]   = dataIdle(i);
      mSclk[i]  = clkIdle(i);
      mPos[i]   = 0;
    end else begin
      fallNow  = mPrev[i] && !sclk;
      mDone[i] = 1'b0;
      if (!mBusy[i]) begin
        mReady[i] = 1'b1;
        mSer[i]   = dataIdle(i);
        mSclk[i]  = clkIdle(i);
        if (fallNow && en) begin
          loadWord(i, par);
          mBusy[i]  = 1'b1;
          mReady[i] = 1'b0;
          mSclk[i]  = sclk;
        end
      end else begin
        mSclk[i] = sclk;
        if (fallNow) begin
          if (mPos[i] < BITS) begin
            mSer[i] = mBits[i][mPos[i]];
            mPos[i]++;
          end else begin
            mDone[i] = 1'b1;
            if (en) begin
              loadWord(i, par);
            end else begin
              mBusy[i]  = 1'b0;
              mReady[i] = 1'b1;
              mSer[i]   = dataIdle(i);
              mSclk[i]  = clkIdle(i);
            end
          end
        end
      end
      mPrev[i] = sclk;
    end
  endtask

  // Drives one cycle of inputs and advances the divided clock. It predicts
  // the result, then compares both instances one time unit after the edge.
  task automatic applyStimulus(input bit rst, input bit en,
                               input logic [BITS-1:0] par);
    in_rst      = rst;
    in_enable   = en;
    in_parallel = par;
    if (sclkRun) sclkPhase = (sclkPhase + 1) % sclkPeriod;
    in_serial_clk = (sclkPhase < sclkPeriod / 2);
    for (int i = 0; i < NUM_DUT; i++)
      modelStep(i, rst, in_serial_clk, en, par);
    @(posedge in_clk);
    #1;
    cycle++;
    checkOutput("msb.ready", ready_m, mReady[0]);
    checkOutput("msb.done",  done_m,  mDone[0]);
    checkOutput("msb.ser",   ser_m,   mSer[0]);
    checkOutput("msb.sclk",  sclk_m,  mSclk[0]);
    checkOutput("lsb.ready", ready_l, mReady[1]);
    checkOutput("lsb.done",  done_l,  mDone[1]);
    checkOutput("lsb.ser",   ser_l,   mSer[1]);
    checkOutput("lsb.sclk",  sclk_l,  mSclk[1]);
    if (done_m === 1'b1) begin
      doneCount++;
      doneGap       = cycle - lastDoneCycle;
      lastDoneCycle = cycle;
    end
  endtask

  // Holds in_enable with a word until the model has loaded it. The loop is
  // bounded, so a stuck divided clock cannot hang the run.
  task automatic loadAndRun(input logic [BITS-1:0] par);
    for (int n = 0; n < 40 && !mBusy[0]; n++)
      applyStimulus(1'b0, 1'b1, par);
  endtask

  // Directed scenarios first, then randomized segments with random
  // divided-clock periods, requests, occasional resets and clock stalls.
  initial begin
    in_rst        = 1'b1;
    in_enable     = 1'b0;
    in_parallel   = '0;
    in_serial_clk = 1'b1;
    doneCount     = 0;
    lastDoneCycle = 0;
    doneGap       = 0;

    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("reset.ready", ready_m, 1);
    checkOutput("reset.ser",   ser_m,   0);
    checkOutput("reset.sclk",  sclk_m,  1);

    loadAndRun(8'hA5);
    for (int n = 0; n < 80; n++) applyStimulus(1'b0, 1'b0, 8'hA5);

    doneCount = 0;
    loadAndRun(8'h3C);
    for (int n = 0; n < 140; n++)
      applyStimulus(1'b0, (n < 70), (n < 40) ? 8'h3C : 8'hC3);
    checkOutput("b2b.doneCount", doneCount, 2);
    checkOutput("b2b.doneGap",   doneGap,   64);

    loadAndRun(8'hFF);
    for (int n = 0; n < 24; n++) applyStimulus(1'b0, 1'b0, 8'hFF);
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("abort.ser",   ser_m,   0);
    checkOutput("abort.sclk",  sclk_m,  1);
    checkOutput("abort.ready", ready_m, 1);
    checkOutput("abort.done",  done_m,  0);
    loadAndRun(8'h81);
    for (int n = 0; n < 80; n++) applyStimulus(1'b0, 1'b0, 8'h81);

    for (int n = 0; n < 20 && sclkPhase != sclkPeriod - 1; n++)
      applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h55);
    applyStimulus(1'b0, 1'b1, 8'h55);
    for (int n = 0; n < 20; n++) applyStimulus(1'b0, 1'b0, 8'h55);
    checkOutput("pulse.ready", ready_m, 1);
    checkOutput("pulse.sclk",  sclk_m,  1);

    loadAndRun(8'hF0);
    for (int n = 0; n < 80; n++)
      applyStimulus(1'b0, 1'b0, (n < 10) ? 8'hF0 : 8'h0F);

    for (int seg = 0; seg < 6; seg++) begin
      sclkPeriod = 2 * $urandom_range(1, 8);
      sclkPhase  = 0;
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 49) == 0) sclkRun = !sclkRun;
        applyStimulus(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 3) != 0),
                      BITS'($urandom));
      end
      sclkRun = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
